disp_ctl_frame: RTL and testbench

Parametrised display frame builder; next generation of the one-page segment controller. On each start pulse, while enabled, it walks the N_CHAR characters of the selected display-memory page and resolves each to a segment byte. Each character is a literal code or a live time-of-day digit, passed through the character-generator LUT and XORed with its mask byte. Results build a shadow frame, committed atomically to the segment driver output. Sits between the time-of-day counter, the shared display BRAM/LUT, and the segment driver.

---
 rtl/types_pkg.sv | 29 ++
 rtl/disp_digit_sel.sv | 31 +++
 rtl/disp_ctl_frame.sv | 177 +++++++++++++++++
 tb/tb_disp_ctl_frame.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared display types: BCD time-of-day record, LUT region base and the
// digit-select codes carried in the low nibble of a live-digit character.
package types_pkg;

  typedef struct packed {
    logic [3:0] t_10h;
    logic [3:0] t_1h;
    logic [3:0] t_10m;
    logic [3:0] t_1m;
    logic [3:0] t_10s;
    logic [3:0] t_1s;
    logic [3:0] t_100ms;
    logic [3:0] t_10ms;
    logic [3:0] t_1ms;
  } time_t;

  localparam logic [3:0] LUT_BASE = 4'b1000;

  localparam logic [3:0] DSEL_1MS   = 4'd0;
  localparam logic [3:0] DSEL_10MS  = 4'd1;
  localparam logic [3:0] DSEL_100MS = 4'd2;
  localparam logic [3:0] DSEL_1S    = 4'd3;
  localparam logic [3:0] DSEL_10S   = 4'd4;
  localparam logic [3:0] DSEL_1M    = 4'd5;
  localparam logic [3:0] DSEL_10M   = 4'd6;
  localparam logic [3:0] DSEL_1H    = 4'd7;
  localparam logic [3:0] DSEL_10H   = 4'd8;

endpackage

// File: rtl/disp_digit_sel.sv
// Resolves a display-memory character to the character-generator code:
// literals pass through, live-digit codes become ASCII '0'..'9' from cur_time.
module disp_digit_sel
  import types_pkg::*;
(
  input  time_t      cur_time,
  input  logic [7:0] lchar,
  output logic [7:0] dchar
);

  logic [3:0] digit;

  always_comb begin
    digit = 4'd0;
    case (lchar[3:0])
      DSEL_1MS:   digit = cur_time.t_1ms;
      DSEL_10MS:  digit = cur_time.t_10ms;
      DSEL_100MS: digit = cur_time.t_100ms;
      DSEL_1S:    digit = cur_time.t_1s;
      DSEL_10S:   digit = cur_time.t_10s;
      DSEL_1M:    digit = cur_time.t_1m;
      DSEL_10M:   digit = cur_time.t_10m;
      DSEL_1H:    digit = cur_time.t_1h;
      DSEL_10H:   digit = cur_time.t_10h;
      default:    digit = 4'd0;
    endcase
    if (lchar[7]) dchar = 8'h30 + {4'h0, digit};
    else          dchar = {1'b0, lchar[6:0]};
  end

endmodule

// File: rtl/disp_ctl_frame.sv
// Display frame builder: walks one display-memory page, resolves each
// character through the LUT and mask, then commits the whole frame at once.
module disp_ctl_frame
  import types_pkg::*;
#(
  parameter int N_CHAR = 32,
  parameter int PAGE_W = 5,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  disp_ena,
  input  logic [PAGE_W-1:0]     disp_page,
  input  logic                  blink_phase,
  input  time_t                 cur_time,
  output logic [ADDR_W-1:0]     lut_addr,
  input  logic [7:0]            lut_data,
  output logic [N_CHAR*8-1:0]   disp_data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(N_CHAR);
  localparam logic [ADDR_W-1:0] LUT_ADDR_BASE = {LUT_BASE, {(ADDR_W-4){1'b0}}};

  typedef enum logic [10:0] {
    IDLE   = 11'b000_0000_0001,
    CHAR_A = 11'b000_0000_0010,
    MASK_A = 11'b000_0000_0100,
    CHAR_D = 11'b000_0000_1000,
    MASK_D = 11'b000_0001_0000,
    CONV   = 11'b000_0010_0000,
    LUT_A  = 11'b000_0100_0000,
    LUT_W  = 11'b000_1000_0000,
    LUT_D  = 11'b001_0000_0000,
    INS    = 11'b010_0000_0000,
    COMMIT = 11'b100_0000_0000
  } state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [PAGE_W-1:0]           page_q, page_d;
  logic                        blink_q, blink_d;
  logic [7:0]                  lchar_q, lchar_d;
  logic [7:0]                  mask_q, mask_d;
  logic [7:0]                  dchar_q, dchar_d;
  logic [7:0]                  seg_q, seg_d;
  logic [ADDR_W-1:0]           lut_addr_q, lut_addr_d;
  logic [N_CHAR-1:0][7:0]      shadow_q, shadow_d;
  logic [N_CHAR-1:0][7:0]      disp_q, disp_d;
  logic                        frame_done_q, frame_done_d;

  logic [7:0]                  dchar_w;
  logic [ADDR_W-1:0]           char_addr;

  // Char byte sits at even address, its mask byte at the following odd one.
  assign char_addr = ADDR_W'({page_q, idx_q, 1'b0});

  disp_digit_sel u_digit_sel (
    .cur_time (cur_time),
    .lchar    (lchar_q),
    .dchar    (dchar_w)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    page_d       = page_q;
    blink_d      = blink_q;
    lchar_d      = lchar_q;
    mask_d       = mask_q;
    dchar_d      = dchar_q;
    seg_d        = seg_q;
    lut_addr_d   = lut_addr_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && disp_ena) begin
          page_d  = disp_page;
          blink_d = blink_phase;
          idx_d   = '0;
          state_d = CHAR_A;
        end
      end
      CHAR_A: begin
        lut_addr_d = char_addr;
        state_d    = MASK_A;
      end
      MASK_A: begin
        lut_addr_d = char_addr | ADDR_W'(1);
        state_d    = CHAR_D;
      end
      CHAR_D: begin
        lchar_d = lut_data;
        state_d = MASK_D;
      end
      MASK_D: begin
        mask_d  = lut_data;
        state_d = CONV;
      end
      CONV: begin
        dchar_d = dchar_w;
        state_d = LUT_A;
      end
      LUT_A: begin
        lut_addr_d = LUT_ADDR_BASE | ADDR_W'(dchar_q);
        state_d    = LUT_W;
      end
      LUT_W: state_d = LUT_D;
      LUT_D: begin
        seg_d   = (blink_q && lchar_q[7:6] == 2'b11) ? 8'h00 : lut_data;
        state_d = INS;
      end
      INS: begin
        shadow_d[idx_q] = seg_q ^ mask_q;
        if (idx_q == IDX_W'(N_CHAR - 1)) begin
          state_d = COMMIT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = CHAR_A;
        end
      end
      COMMIT: begin
        disp_d       = shadow_q;
        frame_done_d = 1'b1;
        idx_d        = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Losing enable abandons the partial frame; the displayed frame stays.
    if (state_q != IDLE && !disp_ena) begin
      state_d      = IDLE;
      disp_d       = disp_q;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      page_q       <= '0;
      blink_q      <= 1'b0;
      lchar_q      <= '0;
      mask_q       <= '0;
      dchar_q      <= '0;
      seg_q        <= '0;
      lut_addr_q   <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      page_q       <= page_d;
      blink_q      <= blink_d;
      lchar_q      <= lchar_d;
      mask_q       <= mask_d;
      dchar_q      <= dchar_d;
      seg_q        <= seg_d;
      lut_addr_q   <= lut_addr_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lut_addr   = lut_addr_q;
  assign disp_data  = disp_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_ctl_frame.sv
// Bench for disp_ctl_frame: a default 32-char build and an 8-char/7-bit-page
// build share one BRAM image; frames are checked against a byte-level model.
module tb_disp_ctl_frame;
  import types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  time_t       cur_time;

  logic        start0, ena0, blink0;
  logic [4:0]  page0;
  logic [11:0] lut_addr0;
  logic [7:0]  lut_data0;
  logic [255:0] dd0;
  logic        busy0, fd0;

  logic        start1, ena1, blink1;
  logic [6:0]  page1;
  logic [11:0] lut_addr1;
  logic [7:0]  lut_data1;
  logic [63:0] dd1;
  logic        busy1, fd1;

  logic [7:0]  mem [0:4095];
  int          n_vec = 0;
  int          n_err = 0;
  int          fd0_cnt = 0;

  disp_ctl_frame u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .disp_ena(ena0),
    .disp_page(page0), .blink_phase(blink0), .cur_time(cur_time),
    .lut_addr(lut_addr0), .lut_data(lut_data0), .disp_data(dd0),
    .busy(busy0), .frame_done(fd0)
  );

  disp_ctl_frame #(.N_CHAR(8), .PAGE_W(7), .ADDR_W(12)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .disp_ena(ena1),
    .disp_page(page1), .blink_phase(blink1), .cur_time(cur_time),
    .lut_addr(lut_addr1), .lut_data(lut_data1), .disp_data(dd1),
    .busy(busy1), .frame_done(fd1)
  );

  // Synchronous-read BRAM: data appears two cycles after the issuing state.
  always @(posedge clk) begin
    lut_data0 <= mem[lut_addr0];
    lut_data1 <= mem[lut_addr1];
    if (fd0) fd0_cnt <= fd0_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int nidxw(input int sel);
    return (sel != 0) ? 3 : 5;
  endfunction

  function automatic int nch(input int sel);
    return (sel != 0) ? 8 : 32;
  endfunction

  function automatic logic get_fd(input int sel);
    return (sel != 0) ? fd1 : fd0;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction

  function automatic logic [11:0] get_addr(input int sel);
    return (sel != 0) ? lut_addr1 : lut_addr0;
  endfunction

  function automatic logic [7:0] get_byte(input int sel, input int i);
    return (sel != 0) ? dd1[8*i +: 8] : dd0[8*i +: 8];
  endfunction

  function automatic logic [7:0] digit_of(input logic [3:0] code);
    case (code)
      4'd0: return {4'h0, cur_time.t_1ms};
      4'd1: return {4'h0, cur_time.t_10ms};
      4'd2: return {4'h0, cur_time.t_100ms};
      4'd3: return {4'h0, cur_time.t_1s};
      4'd4: return {4'h0, cur_time.t_10s};
      4'd5: return {4'h0, cur_time.t_1m};
      4'd6: return {4'h0, cur_time.t_10m};
      4'd7: return {4'h0, cur_time.t_1h};
      4'd8: return {4'h0, cur_time.t_10h};
      default: return 8'h00;
    endcase
  endfunction

  function automatic int char_addr(input int sel, input int page, input int idx);
    return page * (2 ** (nidxw(sel) + 1)) + 2 * idx;
  endfunction

  function automatic logic [7:0] exp_dchar(input int sel, input int page, input int idx);
    logic [7:0] lc;
    lc = mem[char_addr(sel, page, idx)];
    if (!lc[7]) return {1'b0, lc[6:0]};
    return 8'h30 + digit_of(lc[3:0]);
  endfunction

  function automatic logic [7:0] exp_byte(input int sel, input int page, input int idx, input bit blink);
    logic [7:0] lc, mk, seg;
    int ca;
    ca  = char_addr(sel, page, idx);
    lc  = mem[ca];
    mk  = mem[ca + 1];
    seg = (lc[7] && lc[6] && blink) ? 8'h00 : mem[2048 + int'(exp_dchar(sel, page, idx))];
    return seg ^ mk;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
  endtask

  task automatic rand_time();
    cur_time.t_1ms   = 4'($urandom_range(0, 9));
    cur_time.t_10ms  = 4'($urandom_range(0, 9));
    cur_time.t_100ms = 4'($urandom_range(0, 9));
    cur_time.t_1s    = 4'($urandom_range(0, 9));
    cur_time.t_10s   = 4'($urandom_range(0, 5));
    cur_time.t_1m    = 4'($urandom_range(0, 9));
    cur_time.t_10m   = 4'($urandom_range(0, 5));
    cur_time.t_1h    = 4'($urandom_range(0, 9));
    cur_time.t_10h   = 4'($urandom_range(0, 2));
  endtask

  task automatic drive_start(input int sel, input int page, input bit blink);
    if (sel == 0) begin
      start0 = 1'b1; ena0 = 1'b1; page0 = 5'(page); blink0 = blink;
    end else begin
      start1 = 1'b1; ena1 = 1'b1; page1 = 7'(page); blink1 = blink;
    end
  endtask

  // Drop start and scramble page/blink so only the latched values count.
  task automatic drop_start(input int sel);
    if (sel == 0) begin
      start0 = 1'b0; page0 = 5'($urandom); blink0 = 1'($urandom);
    end else begin
      start1 = 1'b0; page1 = 7'($urandom); blink1 = 1'($urandom);
    end
  endtask

  task automatic check_bytes(input int sel, input int page, input bit blink);
    for (int i = 0; i < nch(sel); i++)
      check($sformatf("byte%0d", i), get_byte(sel, i), exp_byte(sel, page, i, blink));
  endtask

  task automatic run_frame(input int sel, input int page, input bit blink);
    int cyc;
    int exp_len;
    logic [11:0] ca;
    exp_len = 2 + 9 * nch(sel);
    ca = 12'(char_addr(sel, page, 0));
    @(negedge clk);
    drive_start(sel, page, blink);
    tick(); cyc = 1;
    drop_start(sel);
    check("busy_rise", get_busy(sel), 1);
    tick(); cyc = 2;
    check("addr_char", get_addr(sel), ca);
    tick(); cyc = 3;
    check("addr_mask", get_addr(sel), ca | 12'h001);
    repeat (4) begin tick(); cyc++; end
    check("addr_lut", get_addr(sel), 12'h800 | {4'h0, exp_dchar(sel, page, 0)});
    while (!get_fd(sel) && cyc < exp_len + 20) begin tick(); cyc++; end
    check("frame_len", cyc, exp_len);
    check("busy_fall", get_busy(sel), 0);
    check_bytes(sel, page, blink);
    tick();
    check("done_pulse", get_fd(sel), 0);
  endtask

  initial begin
    int cyc, c0, pg;
    logic [255:0] d_before;

    rst_n = 1'b0;
    start0 = 1'b0; ena0 = 1'b0; page0 = '0; blink0 = 1'b0;
    start1 = 1'b0; ena1 = 1'b0; page1 = '0; blink1 = 1'b0;
    cur_time = '0;
    fill_mem();
    repeat (3) @(negedge clk);
    check("rst_addr", lut_addr0, 0);
    check("rst_data", {63'h0, |dd0}, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", fd0, 0);
    rst_n = 1'b1;
    tick();

    // page 3: every char 'A' with zero mask, LUT['A'] = 0x77
    for (int i = 0; i < 32; i++) begin
      mem[char_addr(0, 3, i)]     = 8'h41;
      mem[char_addr(0, 3, i) + 1] = 8'h00;
    end
    mem[12'h841] = 8'h77;
    run_frame(0, 3, 1'b0);
    check("page3_b0", dd0[7:0], 8'h77);
    check("page3_b31", dd0[255:248], 8'h77);

    // live 1s digit with mask 0x80
    cur_time.t_1s = 4'd7;
    mem[char_addr(0, 5, 0)]     = 8'h83;
    mem[char_addr(0, 5, 0) + 1] = 8'h80;
    run_frame(0, 5, 1'b0);
    check("digit_1s", dd0[7:0], mem[12'h837] ^ 8'h80);

    // blinking live 1m digit, both phases
    cur_time.t_1m = 4'd5;
    mem[char_addr(0, 6, 0)]     = 8'hC5;
    mem[char_addr(0, 6, 0) + 1] = 8'h01;
    run_frame(0, 6, 1'b1);
    check("blink_on", dd0[7:0], 8'h01);
    run_frame(0, 6, 1'b0);
    check("blink_off", dd0[7:0], mem[12'h835] ^ 8'h01);

    for (int k = 0; k < 4; k++) begin
      fill_mem();
      rand_time();
      run_frame(0, $urandom_range(0, 31), 1'($urandom));
    end

    // enable dropped mid-frame
    d_before = dd0;
    c0 = fd0_cnt;
    @(negedge clk);
    drive_start(0, 9, 1'b0);
    tick(); cyc = 1;
    drop_start(0);
    while (cyc < 100) begin tick(); cyc++; end
    ena0 = 1'b0;
    tick();
    check("abort_busy", busy0, 0);
    repeat (3) tick();
    ena0 = 1'b1;
    repeat (300) tick();
    check("abort_no_done", fd0_cnt - c0, 0);
    check("abort_hold", {63'h0, dd0 == d_before}, 1);
    pg = $urandom_range(0, 31);
    run_frame(0, pg, 1'b1);

    // second start while busy is ignored
    c0 = fd0_cnt;
    pg = $urandom_range(0, 31);
    @(negedge clk);
    drive_start(0, pg, 1'b0);
    tick(); cyc = 1;
    drop_start(0);
    while (cyc < 50) begin tick(); cyc++; end
    start0 = 1'b1;
    tick(); cyc++;
    start0 = 1'b0;
    while (!fd0 && cyc < 320) begin tick(); cyc++; end
    check("restart_len", cyc, 290);
    check_bytes(0, pg, 1'b0);
    repeat (300) tick();
    check("restart_one_done", fd0_cnt - c0, 1);

    // 8-char / 7-bit page build
    fill_mem();
    rand_time();
    run_frame(1, $urandom_range(0, 127), 1'b1);
    run_frame(1, $urandom_range(0, 127), 1'b0);

    // asynchronous reset mid-frame
    @(negedge clk);
    drive_start(0, 17, 1'b0);
    tick();
    drop_start(0);
    repeat (120) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_addr", lut_addr0, 0);
    check("mid_rst_data", {63'h0, |dd0}, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_done", fd0, 0);
    check("mid_rst_data1", dd1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_frame(0, $urandom_range(0, 31), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
